// File: rtl/subckt_tb_pkg.sv
// -----------------------------------------------------------------------------
// subckt_tb_pkg
// Shared definitions for the benchmark-subcircuit stimulus source and its
// response-side monitor model:
//   state_e        - run-control states of the stimulus generator
//   LFSR_POLY      - default Galois feedback mask (taps 16,14,13,11)
//   LFSR_DEF_SEED  - default LFSR value after reset (nonzero)
//   lfsr_step()    - one Galois LFSR step on a zero-extended register value
// -----------------------------------------------------------------------------
package subckt_tb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Widest LFSR the shared step function supports; narrower registers are
    // zero-extended on the way in and truncated on the way out.
    localparam int unsigned LFSR_MAX_W = 32;

    localparam logic [15:0] LFSR_POLY     = 16'hB400;
    localparam logic [15:0] LFSR_DEF_SEED = 16'hACE1;

    // Galois step: shift right, fold the mask in when the bit shifted out is 1.
    // The upper zero-extension bits stay zero as long as poly fits the register.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
        input logic [LFSR_MAX_W-1:0] cur,
        input logic [LFSR_MAX_W-1:0] poly
    );
        logic [LFSR_MAX_W-1:0] shifted;
        shifted = {1'b0, cur[LFSR_MAX_W-1:1]};
        return cur[0] ? (shifted ^ poly) : shifted;
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// -----------------------------------------------------------------------------
// lfsr_galois
// Galois LFSR with step enable and parallel load.
//   clk_i       in   clock
//   rst_ni      in   asynchronous active-low reset (loads DEF_SEED)
//   en_i        in   advance the LFSR by one step
//   load_i      in   load load_val_i (takes priority over en_i)
//   load_val_i  in   seed value; an all-zero seed is replaced by 1 so the
//                    register can never lock up in the all-zero state
//   lfsr_o      out  current LFSR value
// -----------------------------------------------------------------------------
module lfsr_galois
    import subckt_tb_pkg::*;
#(
    parameter int unsigned          LFSR_W   = 16,
    parameter logic [LFSR_W-1:0]    POLY     = LFSR_W'(LFSR_POLY),
    parameter logic [LFSR_W-1:0]    DEF_SEED = LFSR_W'(LFSR_DEF_SEED)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] load_val_i,
    output logic [LFSR_W-1:0] lfsr_o
);

    localparam logic [LFSR_W-1:0] ONE = {{(LFSR_W-1){1'b0}}, 1'b1};

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // Next LFSR value: load (with zero-seed guard), step, or hold
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            if (load_val_i == {LFSR_W{1'b0}}) begin
                lfsr_d = ONE;
            end else begin
                lfsr_d = load_val_i;
            end
        end else if (en_i) begin
            lfsr_d = LFSR_W'(lfsr_step(LFSR_MAX_W'(lfsr_q), LFSR_MAX_W'(POLY)));
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // LFSR register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= DEF_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/subckt_stim_gen.sv
// -----------------------------------------------------------------------------
// subckt_stim_gen
// Pseudo-random stimulus source for the Nt-node benchmark subcircuits. Offers
// one LFSR pattern per valid/ready transfer for NUM_PAT transfers, then drains
// for LATENCY cycles so every capture strobe still in flight is emitted.
//   I1470_clk   in   clock (rising edge)
//   I1477_rst   in   asynchronous active-low reset, released synchronously
//   start       in   begin a run (IDLE/DONE only)
//   seed_load   in   load seed into the LFSR (IDLE/DONE only)
//   seed        in   seed value
//   pat_o       out  stimulus vector = lfsr[WIDTH-1:0]
//   pat_valid   out  pat_o is offered
//   pat_ready   in   consumer accepts pat_o
//   cap_strobe  out  one-cycle pulse LATENCY cycles after each transfer
//   pat_idx     out  transfers accepted in the current run
//   busy        out  RUN or DRAIN
//   done        out  DONE
// -----------------------------------------------------------------------------
module subckt_stim_gen
    import subckt_tb_pkg::*;
#(
    parameter int unsigned          WIDTH    = 4,
    parameter int unsigned          LFSR_W   = 16,
    parameter logic [LFSR_W-1:0]    POLY     = LFSR_W'(LFSR_POLY),
    parameter logic [LFSR_W-1:0]    DEF_SEED = LFSR_W'(LFSR_DEF_SEED),
    parameter int unsigned          NUM_PAT  = 1000,
    parameter int unsigned          LATENCY  = 2,
    parameter int unsigned          CNT_W    = 16
) (
    input  logic              I1470_clk,
    input  logic              I1477_rst,
    input  logic              start,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    output logic [WIDTH-1:0]  pat_o,
    output logic              pat_valid,
    input  logic              pat_ready,
    output logic              cap_strobe,
    output logic [CNT_W-1:0]  pat_idx,
    output logic              busy,
    output logic              done
);

    localparam int unsigned      DRN_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(NUM_PAT - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(LATENCY - 1);

    logic [1:0]         rst_sync_q;
    logic               rst_n_s;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   pat_idx_q, pat_idx_d;
    logic [DRN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [LATENCY-1:0] strb_q, strb_d;
    logic               pat_valid_q, busy_q, done_q;

    logic               xfer_s;
    logic               lfsr_load_s;
    logic [LFSR_W-1:0]  lfsr_s;

    // Reset synchronizer: assertion is immediate, release waits two clock edges
    always_ff @(posedge I1470_clk or negedge I1477_rst) begin
        if (!I1477_rst) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_q[1];
    assign xfer_s  = pat_valid_q & pat_ready;

    lfsr_galois #(
        .LFSR_W   (LFSR_W),
        .POLY     (POLY),
        .DEF_SEED (DEF_SEED)
    ) u_lfsr (
        .clk_i      (I1470_clk),
        .rst_ni     (rst_n_s),
        .en_i       (xfer_s),
        .load_i     (lfsr_load_s),
        .load_val_i (seed),
        .lfsr_o     (lfsr_s)
    );

    // Run control: next state, pattern index, drain counter and seed load
    always_comb begin
        state_d     = state_q;
        pat_idx_d   = pat_idx_q;
        drain_cnt_d = drain_cnt_q;
        lfsr_load_s = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                // Seed load and start may coincide; the LFSR then holds the
                // seed when the first pattern is offered.
                lfsr_load_s = seed_load;
                if (start) begin
                    state_d   = RUN;
                    pat_idx_d = {CNT_W{1'b0}};
                end else begin
                    state_d   = state_q;
                end
            end
            RUN: begin
                if (xfer_s) begin
                    pat_idx_d = pat_idx_q + CNT_W'(1);
                    if (pat_idx_q == IDX_LAST) begin
                        state_d     = DRAIN;
                        drain_cnt_d = {DRN_W{1'b0}};
                    end else begin
                        state_d     = RUN;
                    end
                end else begin
                    pat_idx_d = pat_idx_q;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRN_LAST) begin
                    state_d     = DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRN_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobe delay line: shift in the transfer flag, oldest bit is the strobe
    always_comb begin
        strb_d = LATENCY'({strb_q, xfer_s});
    end

    // Control registers and status flags decoded from the next state
    always_ff @(posedge I1470_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q     <= IDLE;
            pat_idx_q   <= {CNT_W{1'b0}};
            drain_cnt_q <= {DRN_W{1'b0}};
            strb_q      <= {LATENCY{1'b0}};
            pat_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_idx_q   <= pat_idx_d;
            drain_cnt_q <= drain_cnt_d;
            strb_q      <= strb_d;
            pat_valid_q <= (state_d == RUN);
            busy_q      <= (state_d == RUN) || (state_d == DRAIN);
            done_q      <= (state_d == DONE);
        end
    end

    assign pat_o      = lfsr_s[WIDTH-1:0];
    assign pat_valid  = pat_valid_q;
    assign cap_strobe = strb_q[LATENCY-1];
    assign pat_idx    = pat_idx_q;
    assign busy       = busy_q;
    assign done       = done_q;

    // Upper LFSR bits feed only the sequence, not the stimulus vector.
    if (WIDTH < LFSR_W) begin : g_unused_bits
        logic unused_s;
        assign unused_s = ^lfsr_s[LFSR_W-1:WIDTH];
    end

endmodule

// File: tb/tb_subckt_stim_gen.sv
// -----------------------------------------------------------------------------
// tb_subckt_stim_gen
// Self-checking bench for subckt_stim_gen (NUM_PAT=4, LATENCY=2). A behavioural
// reference tracks the LFSR value, the run/drain/done progress and a list of
// absolute cycle numbers at which capture strobes are due.
// -----------------------------------------------------------------------------
module tb_subckt_stim_gen;

    localparam int NP  = 4;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic        seed_load_i;
    logic [15:0] seed_i;
    logic        ready_i;
    logic [3:0]  pat_o;
    logic        pat_valid;
    logic        cap_strobe;
    logic [15:0] pat_idx;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    // reference model state
    int unsigned m_lfsr;
    int          m_idx;
    bit          m_valid, m_busy, m_done;
    int          done_at;
    int          cyc;
    int          strobe_q[$];

    subckt_stim_gen #(
        .NUM_PAT (NP),
        .LATENCY (LAT)
    ) dut (
        .I1470_clk  (clk),
        .I1477_rst  (rst_n),
        .start      (start_i),
        .seed_load  (seed_load_i),
        .seed       (seed_i),
        .pat_o      (pat_o),
        .pat_valid  (pat_valid),
        .pat_ready  (ready_i),
        .cap_strobe (cap_strobe),
        .pat_idx    (pat_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int unsigned ref_step(input int unsigned v);
        return (v >> 1) ^ (((v & 1) != 0) ? 32'hB400 : 32'h0);
    endfunction

    task automatic model_reset();
        m_lfsr  = 32'hACE1;
        m_idx   = 0;
        m_valid = 1'b0;
        m_busy  = 1'b0;
        m_done  = 1'b0;
        done_at = 0;
        strobe_q.delete();
    endtask

    // Apply one rising edge to the reference using the inputs that were driven.
    task automatic model_edge(input bit st, input bit sl, input logic [15:0] sd, input bit rdy);
        bit x;
        bit idle;
        cyc++;
        x    = m_valid && rdy;
        idle = !m_busy;
        if (m_busy && !m_valid && cyc == done_at) begin
            m_busy = 1'b0;
            m_done = 1'b1;
        end
        if (x) begin
            strobe_q.push_back(cyc + LAT - 1);
            m_lfsr = ref_step(m_lfsr);
            m_idx++;
            if (m_idx == NP) begin
                m_valid = 1'b0;
                done_at = cyc + LAT;
            end
        end
        if (idle) begin
            if (sl) m_lfsr = (sd == 16'h0) ? 32'h1 : 32'(sd);
            if (st) begin
                m_valid = 1'b1;
                m_busy  = 1'b1;
                m_done  = 1'b0;
                m_idx   = 0;
            end
        end
    endtask

    task automatic compare_all();
        bit exp_cap;
        exp_cap = 1'b0;
        while (strobe_q.size() > 0 && strobe_q[0] < cyc) void'(strobe_q.pop_front());
        if (strobe_q.size() > 0 && strobe_q[0] == cyc) begin
            exp_cap = 1'b1;
            void'(strobe_q.pop_front());
        end
        check_val("pat_valid", 32'(pat_valid), 32'(m_valid));
        check_val("busy", 32'(busy), 32'(m_busy));
        check_val("done", 32'(done), 32'(m_done));
        check_val("cap_strobe", 32'(cap_strobe), 32'(exp_cap));
        check_val("pat_idx", 32'(pat_idx), 32'(m_idx));
        check_val("pat_o", 32'(pat_o), m_lfsr & 32'hF);
    endtask

    // One clock: drive inputs (at negedge), edge, then compare at next negedge.
    task automatic cycle(input bit st, input bit sl, input logic [15:0] sd, input bit rdy);
        start_i     = st;
        seed_load_i = sl;
        seed_i      = sd;
        ready_i     = rdy;
        @(posedge clk);
        model_edge(st, sl, sd, rdy);
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_to_idle();
        for (int k = 0; k < 40; k++) begin
            if (!m_busy) break;
            cycle(1'b0, 1'b0, 16'h0, 1'b1);
        end
        check_val("run_ends", 32'(busy), 32'h0);
    endtask

    initial begin
        int          start_cyc;
        logic [15:0] rs;
        int unsigned held;

        model_reset();
        cyc         = 0;
        rst_n       = 1'b0;
        start_i     = 1'b0;
        seed_load_i = 1'b0;
        seed_i      = 16'h0;
        ready_i     = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check_val("rst_valid", 32'(pat_valid), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_done", 32'(done), 32'h0);
        check_val("rst_idx", 32'(pat_idx), 32'h0);
        rst_n = 1'b1;
        repeat (3) cycle(1'b0, 1'b0, 16'h0, 1'b0);

        // default seed run, full-speed, with completion timing
        cycle(1'b1, 1'b0, 16'h0, 1'b1);
        start_cyc = cyc;
        check_val("first_pat", 32'(pat_o), 32'h1);
        for (int k = 0; k < 40; k++) begin
            if (done) break;
            cycle(1'b0, 1'b0, 16'h0, 1'b1);
        end
        check_val("run_len", 32'(cyc - start_cyc + 1), 32'(NP + LAT + 1));
        check_val("done_idx", 32'(pat_idx), 32'(NP));

        // seed 1 sequence
        cycle(1'b0, 1'b1, 16'h0001, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b1);
        check_val("seed_p0", 32'(pat_o), 32'h1);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        check_val("seed_i1", 32'(pat_idx), 32'h1);
        check_val("seed_p1", 32'(pat_o), 32'h0);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        check_val("seed_i2", 32'(pat_idx), 32'h2);
        check_val("seed_p2", 32'(pat_o), 32'h0);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        check_val("seed_i3", 32'(pat_idx), 32'h3);
        run_to_idle();

        // zero seed guard, then start/seed_load ignored during RUN
        cycle(1'b1, 1'b1, 16'h0000, 1'b0);
        check_val("zero_seed", 32'(pat_o), 32'h1);
        cycle(1'b1, 1'b1, 16'h5555, 1'b1);
        cycle(1'b0, 1'b1, 16'h7777, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b1);
        run_to_idle();

        // backpressure: two transfers, five stalled cycles, then resume
        cycle(1'b1, 1'b0, 16'h0, 1'b1);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        held = m_lfsr & 32'hF;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b0, 16'h0, 1'b0);
            check_val("bp_pat", 32'(pat_o), held);
            check_val("bp_idx", 32'(pat_idx), 32'h2);
        end
        run_to_idle();

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            rs = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, rs,
                  $urandom_range(0, 3) != 0);
        end
        run_to_idle();

        // reset in the middle of a run with strobes in flight
        cycle(1'b1, 1'b0, 16'h0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            if (m_idx == 2) break;
            cycle(1'b0, 1'b0, 16'h0, 1'b1);
        end
        check_val("mid_idx", 32'(pat_idx), 32'h2);
        rst_n = 1'b0;
        #1;
        check_val("mr_valid", 32'(pat_valid), 32'h0);
        check_val("mr_busy", 32'(busy), 32'h0);
        check_val("mr_cap", 32'(cap_strobe), 32'h0);
        check_val("mr_idx", 32'(pat_idx), 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) cycle(1'b0, 1'b0, 16'h0, 1'b1);
        for (int k = 0; k < 60; k++) begin
            cycle($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, 16'($urandom),
                  $urandom_range(0, 2) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
